// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction fetch/addressing sequencer:
// sequencer states, addressing modes and the default reset-vector address.
package cpu_sequencer_pkg;

    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;

    typedef enum logic [3:0] {
        VEC_LO,
        VEC_HI,
        FETCH_OP,
        DECODE_AM,
        OPR_LO,
        OPR_HI,
        PTR_LO,
        PTR_HI,
        ISSUE,
        WAIT_DONE
    } seq_state_t;

    typedef enum logic [3:0] {
        AM_IMP,
        AM_IMM,
        AM_REL,
        AM_ZPG,
        AM_ZPX,
        AM_ZPY,
        AM_ABS,
        AM_ABX,
        AM_ABY,
        AM_INX,
        AM_INY
    } addr_mode_t;

endpackage

// File: rtl/cpu_sequencer_am_classify.sv
// Combinational opcode -> addressing-mode classifier (6502-style bbb/cc grid).
module am_classify
    import cpu_sequencer_pkg::*;
(
    input  logic [7:0]  opcode,
    output addr_mode_t  mode
);

    logic [2:0] bbb;
    logic [1:0] cc;

    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    // Group cc=01 has a regular mode column; the other groups carry a few
    // opcode-specific exceptions (LDX/STX use Y as the index register).
    always_comb begin
        mode = AM_IMP;
        if (cc == 2'b01) begin
            case (bbb)
                3'b000:  mode = AM_INX;
                3'b001:  mode = AM_ZPG;
                3'b010:  mode = AM_IMM;
                3'b011:  mode = AM_ABS;
                3'b100:  mode = AM_INY;
                3'b101:  mode = AM_ZPX;
                3'b110:  mode = AM_ABY;
                default: mode = AM_ABX;
            endcase
        end else begin
            case (bbb)
                3'b000:  mode = opcode[7] ? AM_IMM : AM_IMP;
                3'b001:  mode = AM_ZPG;
                3'b010:  mode = AM_IMP;
                3'b011:  mode = AM_ABS;
                3'b100:  mode = AM_REL;
                3'b101:  mode = (opcode == 8'h96 || opcode == 8'hB6) ? AM_ZPY : AM_ZPX;
                3'b110:  mode = AM_IMP;
                default: mode = (opcode == 8'hBE) ? AM_ABY : AM_ABX;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: loads the PC from the reset vector, fetches opcodes
// and operand bytes over a single-outstanding read port, resolves the
// effective address and hands the instruction to the decoder.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    output logic [REG_WIDTH-1:0]  instruction_out,
    output logic [REG_WIDTH-1:0]  operand,
    output logic [ADDR_WIDTH-1:0] eff_addr,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    seq_state_t            state;
    addr_mode_t            am_mode;
    addr_mode_t            am_r;
    logic [ADDR_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0]  lo_byte;
    logic [REG_WIDTH-1:0]  zp_ptr;
    logic                  pc_pend;
    logic [ADDR_WIDTH-1:0] pc_pend_val;
    logic [ADDR_WIDTH-1:0] resume_pc;
    logic                  rd_done;

    // Zero-page address: the byte wraps within page 0.
    function automatic logic [ADDR_WIDTH-1:0] zp_addr(input logic [REG_WIDTH-1:0] b);
        zp_addr      = '0;
        zp_addr[7:0] = b[7:0];
    endfunction

    // Little-endian 16-bit word from two bytes.
    function automatic logic [ADDR_WIDTH-1:0] word(input logic [REG_WIDTH-1:0] hi,
                                                   input logic [REG_WIDTH-1:0] lo);
        word = ADDR_WIDTH'({hi, lo});
    endfunction

    // Index added to a full 16-bit base (no page-cross penalty).
    function automatic logic [ADDR_WIDTH-1:0] index_of(input addr_mode_t m,
                                                       input logic [REG_WIDTH-1:0] x,
                                                       input logic [REG_WIDTH-1:0] y);
        case (m)
            AM_ABX:         index_of = ADDR_WIDTH'(x);
            AM_ABY, AM_INY: index_of = ADDR_WIDTH'(y);
            default:        index_of = '0;
        endcase
    endfunction

    am_classify u_am_classify (
        .opcode (instruction_out[7:0]),
        .mode   (am_mode)
    );

    // A read completes only while it is actually outstanding, so a late
    // rvalid belonging to a read abandoned by reset is dropped.
    assign rd_done = mem_req && mem_rvalid;

    // A PC load in the completing cycle beats one remembered from earlier.
    assign resume_pc = pc_load ? pc_load_val : (pc_pend ? pc_pend_val : pc);

    assign pc_out = pc;

    // Main sequencer: state, PC, memory request and decoder-facing outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= VEC_LO;
            pc                <= '0;
            mem_req           <= 1'b0;
            mem_addr          <= '0;
            instruction_ready <= 1'b0;
            instruction_out   <= '0;
            operand           <= '0;
            eff_addr          <= '0;
            am_r              <= AM_IMP;
            pc_pend           <= 1'b0;
            pc_pend_val       <= '0;
        end else begin
            case (state)
                VEC_LO: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= RESET_VECTOR;
                    end else if (mem_rvalid) begin
                        lo_byte  <= mem_rdata;
                        mem_addr <= RESET_VECTOR + ADDR_WIDTH'(1);
                        state    <= VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (rd_done) begin
                        pc       <= word(mem_rdata, lo_byte);
                        mem_addr <= word(mem_rdata, lo_byte);
                        state    <= FETCH_OP;
                    end
                end
                FETCH_OP: begin
                    if (rd_done) begin
                        instruction_out <= mem_rdata;
                        operand         <= '0;
                        eff_addr        <= '0;
                        pc              <= pc + ADDR_WIDTH'(1);
                        mem_req         <= 1'b0;
                        state           <= DECODE_AM;
                    end
                end
                DECODE_AM: begin
                    am_r <= am_mode;
                    if (am_mode == AM_IMP) begin
                        state <= ISSUE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= OPR_LO;
                    end
                end
                OPR_LO: begin
                    if (rd_done) begin
                        pc      <= pc + ADDR_WIDTH'(1);
                        lo_byte <= mem_rdata;
                        case (am_r)
                            AM_IMM, AM_REL: begin
                                operand <= mem_rdata;
                                mem_req <= 1'b0;
                                state   <= ISSUE;
                            end
                            AM_ZPG: begin
                                eff_addr <= zp_addr(mem_rdata);
                                mem_req  <= 1'b0;
                                state    <= ISSUE;
                            end
                            AM_ZPX: begin
                                eff_addr <= zp_addr(mem_rdata + x_in);
                                mem_req  <= 1'b0;
                                state    <= ISSUE;
                            end
                            AM_ZPY: begin
                                eff_addr <= zp_addr(mem_rdata + y_in);
                                mem_req  <= 1'b0;
                                state    <= ISSUE;
                            end
                            AM_ABS, AM_ABX, AM_ABY: begin
                                mem_addr <= pc + ADDR_WIDTH'(1);
                                state    <= OPR_HI;
                            end
                            AM_INX: begin
                                zp_ptr   <= mem_rdata + x_in;
                                mem_addr <= zp_addr(mem_rdata + x_in);
                                state    <= PTR_LO;
                            end
                            AM_INY: begin
                                zp_ptr   <= mem_rdata;
                                mem_addr <= zp_addr(mem_rdata);
                                state    <= PTR_LO;
                            end
                            default: begin
                                mem_req <= 1'b0;
                                state   <= ISSUE;
                            end
                        endcase
                    end
                end
                OPR_HI: begin
                    if (rd_done) begin
                        pc       <= pc + ADDR_WIDTH'(1);
                        eff_addr <= word(mem_rdata, lo_byte) + index_of(am_r, x_in, y_in);
                        mem_req  <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                PTR_LO: begin
                    if (rd_done) begin
                        lo_byte  <= mem_rdata;
                        mem_addr <= zp_addr(zp_ptr + REG_WIDTH'(1));
                        state    <= PTR_HI;
                    end
                end
                PTR_HI: begin
                    if (rd_done) begin
                        eff_addr <= word(mem_rdata, lo_byte) + index_of(am_r, x_in, y_in);
                        mem_req  <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    instruction_ready <= 1'b1;
                    state             <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (instruction_done) begin
                        instruction_ready <= 1'b0;
                        pc                <= resume_pc;
                        mem_addr          <= resume_pc;
                        mem_req           <= 1'b1;
                        pc_pend           <= 1'b0;
                        state             <= FETCH_OP;
                    end else if (pc_load) begin
                        pc_pend     <= 1'b1;
                        pc_pend_val <= pc_load_val;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= VEC_LO;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address/PC width.
REQ-002 Parameter REG_WIDTH, default 8, data/register width.
REQ-003 Parameter RESET_VECTOR, default 16'hFFFC, address of the reset-vector low byte.
REQ-004 Port clk  in  1  clock; all logic SHALL be rising-edge.
REQ-005 Port reset_n  in  1  reset; synchronous, active-low.
REQ-006 Port mem_req  out  1  read request, held until accepted.
REQ-007 Port mem_addr  out  ADDR_WIDTH  read address.
REQ-008 Port mem_rvalid  in  1  read data valid; completes the pending request.
REQ-009 Port mem_rdata  in  REG_WIDTH  read data.
REQ-010 Port x_in, y_in  in  REG_WIDTH  index registers, sampled in the cycle the offset is applied.
REQ-011 Port instruction_out  out  REG_WIDTH  latched opcode.
REQ-012 Port operand  out  REG_WIDTH  immediate/relative byte (0 if none).
REQ-013 Port eff_addr  out  ADDR_WIDTH  effective address (0 if none).
REQ-014 Port instruction_ready  out  1  opcode/operand/eff_addr valid for the decoder.
REQ-015 Port instruction_done  in  1  decoder completion.
REQ-016 Port pc_load, pc_load_val  in  1/ADDR_WIDTH  PC overwrite (jump/branch), honoured only in WAIT_DONE.
REQ-017 Port pc_out  out  ADDR_WIDTH  current PC.

Function
REQ-018 States: VEC_LO, VEC_HI, FETCH_OP, DECODE_AM, OPR_LO, OPR_HI, PTR_LO, PTR_HI, ISSUE, WAIT_DONE.
REQ-019 Memory handshake: at most one outstanding read; mem_addr SHALL be stable while mem_req=1; a byte is consumed on the cycle mem_rvalid=1, and mem_req drops in that same cycle unless a new read is issued in the next state.
REQ-020 VEC_LO/VEC_HI: read RESET_VECTOR, RESET_VECTOR+1; load PC={hi,lo}; go to FETCH_OP.
REQ-021 FETCH_OP: read at PC, latch opcode, PC+=1; go to DECODE_AM (one cycle, no memory access).
REQ-022 Mode from opcode[4:2] (bbb), opcode[1:0] (cc). cc=01: 000 (zp,X), 001 zpg, 010 imm, 011 abs, 100 (zp),Y, 101 zpg,X, 110 abs,Y, 111 abs,X.
REQ-023 cc!=01: 000 imm if opcode[7]=1 else implied; 001 zpg; 010 implied; 011 abs; 100 relative (1 byte, to operand); 101 zpg,X (zpg,Y for 8'h96/8'hB6); 110 implied; 111 abs,X (abs,Y for 8'hBE).
REQ-024 Each operand byte read at PC SHALL increment PC by 1; PC wraps 16'hFFFF->16'h0000.
REQ-025 Zero-page indexed: eff_addr={8'h00,(zp+idx) mod 256}.
REQ-026 (zp,X): pointer bytes at (zp+X) mod 256 and (zp+X+1) mod 256.
REQ-027 (zp),Y: pointer bytes at zp and (zp+1) mod 256; eff_addr=(ptr+Y) mod 65536.
REQ-028 abs,X / abs,Y: eff_addr=({hi,lo}+idx) mod 65536, no extra cycle on page cross.
REQ-029 Implied: no operand reads; DECODE_AM->ISSUE.
REQ-030 ISSUE: assert instruction_ready; go to WAIT_DONE. instruction_ready, instruction_out, operand and eff_addr SHALL hold constant until instruction_done is sampled high.
REQ-031 WAIT_DONE: on instruction_done=1, deassert instruction_ready next cycle, go to FETCH_OP; if pc_load=1 in the same or an earlier WAIT_DONE cycle, PC=pc_load_val (last value wins).
REQ-032 instruction_done outside WAIT_DONE SHALL be ignored.
REQ-033 Minimum instruction latency (rvalid same cycle as req): implied 3 cycles from opcode request to instruction_ready.

Reset
REQ-034 reset_n=0 SHALL, at the next edge, force VEC_LO, PC=0, mem_req=0, mem_addr=0, instruction_ready=0, instruction_out=0, operand=0, eff_addr=0, abandoning any pending read or instruction.
REQ-035 A mem_rvalid arriving during or after reset for an abandoned read SHALL be ignored; the first request after release is RESET_VECTOR.

Structure
REQ-036 State encoding, addressing-mode enum (AM_IMP, AM_IMM, AM_REL, AM_ZPG, AM_ZPX, AM_ZPY, AM_ABS, AM_ABX, AM_ABY, AM_INX, AM_INY) and RESET_VECTOR default SHALL live in the shared defines package.
REQ-037 Opcode->mode classification SHALL be a combinational sub-module am_classify.

Verification
REQ-038 Reset, mem[FFFC]=00, mem[FFFD]=80 -> first opcode read at 16'h8000.
REQ-039 Opcode A9, 42 at 8000 -> instruction_ready with instruction_out=A9, operand=42, eff_addr=0; after done, fetch at 8002.
REQ-040 Opcode B5 with zp=F0, X=20 -> eff_addr=16'h0010.
REQ-041 Opcode B1, zp=FF, mem[00FF]=F0, mem[0000]=12, Y=20 -> pointer reads FF then 0000; eff_addr=16'h1310.
REQ-042 instruction_done held low 10 cycles with random mem_rvalid delays -> outputs stable, no memory reads; pc_load=C000 with done -> next fetch at C000.
REQ-043 reset_n low during OPR_HI with late mem_rvalid -> mem_req low, stale data ignored, vector refetch from FFFC.
